// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential Booth multiplier.
//   state_t     - controller states (IDLE, RUN, DONE)
//   recode_t    - radix-4 partial-product selection (0, +M, +2M, -M, -2M)
//   recode()    - maps a 3-bit overlapping multiplier group to recode_t
//   step_count()- number of Booth steps for a given operand width / radix
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } recode_t;

    function automatic recode_t recode(input logic [2:0] grp);
        recode_t r;
        case (grp)
            3'b001, 3'b010: r = PM;
            3'b011:         r = P2M;
            3'b100:         r = N2M;
            3'b101, 3'b110: r = NM;
            default:        r = ZERO;
        endcase
        return r;
    endfunction

    // Operands are processed at WIDTH+2 bits so that both signed and
    // unsigned values are representable as two's complement.
    function automatic int unsigned step_count(input int unsigned width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 2;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational Booth iteration.
//   a      - accumulator (E bits)
//   q      - multiplier register with appended low bit (E+1 bits)
//   m      - multiplicand (E bits, already sign/zero extended)
//   a_next - accumulator after add/subtract and arithmetic shift
//   q_next - multiplier register after shift
// RADIX4=0 consumes one multiplier bit per step, RADIX4=1 consumes two.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned E      = 34,
    parameter bit          RADIX4 = 1'b0
) (
    input  logic [E-1:0] a,
    input  logic [E:0]   q,
    input  logic [E-1:0] m,
    output logic [E-1:0] a_next,
    output logic [E:0]   q_next
);

    if (RADIX4) begin : g_radix4
        localparam logic [E:0] ONE = {{E{1'b0}}, 1'b1};
        // One guard bit so that +/-2M cannot wrap the accumulator.
        logic [E:0] a_g;
        logic [E:0] m_g;
        logic [E:0] sum;

        always_comb begin
            a_g = {a[E-1], a};
            m_g = {m[E-1], m};
            case (recode(q[2:0]))
                PM:      sum = a_g + m_g;
                P2M:     sum = a_g + {m_g[E-1:0], 1'b0};
                NM:      sum = a_g + ~m_g + ONE;
                N2M:     sum = a_g + ~{m_g[E-1:0], 1'b0} + ONE;
                default: sum = a_g;
            endcase
            // Arithmetic shift of {guarded A, Q} by two; guard bit drops out.
            a_next = {sum[E], sum[E:2]};
            q_next = {sum[1:0], q[E:2]};
        end
    end else begin : g_radix2
        localparam logic [E-1:0] ONE = {{(E-1){1'b0}}, 1'b1};
        logic [E-1:0] sum;

        always_comb begin
            case (q[1:0])
                2'b01:   sum = a + m;
                2'b10:   sum = a + ~m + ONE;
                default: sum = a;
            endcase
            a_next = {sum[E-1], sum[E-1:1]};
            q_next = {sum[0], q[E:1]};
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier, one step per clock.
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   start         - request, accepted in IDLE or DONE
//   signed_op     - 1: two's-complement operands, 0: unsigned
//   multiplicand  - M operand (WIDTH bits)
//   multiplier    - Q operand (WIDTH bits)
//   busy          - high while Booth steps remain
//   done          - one-cycle pulse when product is valid
//   product       - 2*WIDTH-bit result, cleared on the accepting edge
//   ovf           - product does not fit in WIDTH bits
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          RADIX4 = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int unsigned E     = WIDTH + 2;
    localparam int unsigned N     = step_count(WIDTH, RADIX4);
    localparam int unsigned CW    = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    state_t state, state_nx;
    logic   load;

    logic [E-1:0]  a_q, m_q, a_step;
    logic [E:0]    q_q, q_step;
    logic [CW-1:0] cnt;
    logic          signed_q;

    logic [E-1:0]       m_ext, q_ext;
    logic [2*E-1:0]     prod_full;
    logic [2*WIDTH-1:0] prod_low;
    logic               ovf_calc;
    logic               unused_bits;

    assign m_ext = signed_op ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    assign q_ext = signed_op ? {{2{multiplier[WIDTH-1]}}, multiplier}     : {2'b00, multiplier};

    booth_step #(
        .E      (E),
        .RADIX4 (RADIX4)
    ) u_step (
        .a      (a_q),
        .q      (q_q),
        .m      (m_q),
        .a_next (a_step),
        .q_next (q_step)
    );

    assign prod_full   = {a_q, q_q[E:1]};
    assign prod_low    = prod_full[2*WIDTH-1:0];
    assign unused_bits = ^{prod_full[2*E-1:2*WIDTH], q_q[0]};

    always_comb begin
        if (signed_q)
            ovf_calc = prod_low[2*WIDTH-1:WIDTH] != {WIDTH{prod_low[WIDTH-1]}};
        else
            ovf_calc = prod_low[2*WIDTH-1:WIDTH] != '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // RUN spends N cycles stepping and one more cycle capturing the result,
    // so busy covers only the stepping cycles.
    assign busy = (state == RUN) && (cnt != '0);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt      <= '0;
            signed_q <= 1'b0;
            product  <= '0;
            ovf      <= 1'b0;
        end else if (load) begin
            a_q      <= '0;
            q_q      <= {q_ext, 1'b0};
            m_q      <= m_ext;
            cnt      <= N_CNT;
            signed_q <= signed_op;
            product  <= '0;
            ovf      <= 1'b0;
        end else if (state == RUN) begin
            if (cnt != '0) begin
                a_q <= a_step;
                q_q <= q_step;
                cnt <= cnt - 1'b1;
            end else begin
                product <= prod_low;
                ovf     <= ovf_calc;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: drives a radix-2 and a radix-4 instance (WIDTH=32)
// and compares every cycle against a transaction-level arithmetic model.
module tb_booth_mult_seq;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic           start     [2];
    logic           signed_op [2];
    logic [W-1:0]   mcand     [2];
    logic [W-1:0]   mplier    [2];
    logic           busy      [2];
    logic           done      [2];
    logic [2*W-1:0] product   [2];
    logic           ovf       [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(W), .RADIX4(1'b0)) dut_r2 (
        .clk(clk), .reset(reset), .start(start[0]), .signed_op(signed_op[0]),
        .multiplicand(mcand[0]), .multiplier(mplier[0]),
        .busy(busy[0]), .done(done[0]), .product(product[0]), .ovf(ovf[0])
    );

    booth_mult_seq #(.WIDTH(W), .RADIX4(1'b1)) dut_r4 (
        .clk(clk), .reset(reset), .start(start[1]), .signed_op(signed_op[1]),
        .multiplicand(mcand[1]), .multiplier(mplier[1]),
        .busy(busy[1]), .done(done[1]), .product(product[1]), .ovf(ovf[1])
    );

    // ---------------- reference arithmetic ----------------
    function automatic int nsteps(input int d);
        return (d == 0) ? 34 : 17;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb;
        sa = s ? longint'(signed'(a)) : longint'({32'h0, a});
        sb = s ? longint'(signed'(b)) : longint'({32'h0, b});
        return sa * sb;
    endfunction

    function automatic bit ref_ovf(input logic [63:0] p, input bit s);
        longint sp;
        sp = longint'(p);
        if (s) return (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
        return p[63:32] != 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- cycle model ----------------
    bit          run_m  [2];
    int          since  [2];
    logic [63:0] pend_p [2];
    bit          pend_o [2];
    logic [63:0] exp_p  [2];
    bit          exp_o  [2];
    bit          exp_b  [2];
    bit          exp_d  [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                run_m[d] <= 1'b0;
                since[d] <= 0;
                exp_p[d] <= '0;
                exp_o[d] <= 1'b0;
                exp_b[d] <= 1'b0;
                exp_d[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                exp_d[d] <= 1'b0;
                if (run_m[d]) begin
                    since[d] <= since[d] + 1;
                    if (since[d] + 1 == nsteps(d) + 1) begin
                        run_m[d] <= 1'b0;
                        exp_p[d] <= pend_p[d];
                        exp_o[d] <= pend_o[d];
                        exp_d[d] <= 1'b1;
                        exp_b[d] <= 1'b0;
                    end else begin
                        exp_b[d] <= (since[d] + 1 < nsteps(d));
                    end
                end else if (start[d] === 1'b1) begin
                    run_m[d]  <= 1'b1;
                    since[d]  <= 0;
                    pend_p[d] <= ref_mul(mcand[d], mplier[d], signed_op[d]);
                    pend_o[d] <= ref_ovf(ref_mul(mcand[d], mplier[d], signed_op[d]), signed_op[d]);
                    exp_p[d]  <= '0;
                    exp_o[d]  <= 1'b0;
                    exp_b[d]  <= 1'b1;
                end else begin
                    exp_b[d] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !reset) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("cycle d%0d busy", d),    64'(busy[d]),  64'(exp_b[d]));
                check($sformatf("cycle d%0d done", d),    64'(done[d]),  64'(exp_d[d]));
                check($sformatf("cycle d%0d product", d), product[d],    exp_p[d]);
                check($sformatf("cycle d%0d ovf", d),     64'(ovf[d]),   64'(exp_o[d]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rand_operand();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            4:       return 32'($urandom_range(15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Starts one operation; lat = negedges after the accepting edge until done.
    task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int pulse_at, input bit noise,
                         output logic [63:0] p, output bit o, output int lat, output int bc);
        @(negedge clk);
        start[d] = 1'b1; mcand[d] = a; mplier[d] = b; signed_op[d] = s;
        lat = -1; bc = 0;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (busy[d]) bc++;
            if (done[d]) begin
                lat = i;
                break;
            end
            if (i == pulse_at) begin
                start[d] = 1'b1; mcand[d] = 32'd9; mplier[d] = 32'd9;
            end else if (noise && i < nsteps(d) - 2) begin
                start[d] = ($urandom_range(3) == 0);
                mcand[d] = 32'($urandom); mplier[d] = 32'($urandom);
                signed_op[d] = 1'($urandom_range(1));
            end else begin
                start[d] = 1'b0;
            end
        end
        start[d] = 1'b0;
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL d%0d done timeout: actual=no done in 100 cycles required=done", d);
        end
        p = product[d];
        o = ovf[d];
        @(negedge clk);
        check($sformatf("d%0d done one cycle", d), 64'(done[d]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] p;
        bit          o;
        int          lat, bc;
        logic [31:0] ra, rb;
        bit          rs;

        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; signed_op[d] = 1'b0; mcand[d] = '0; mplier[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset d%0d busy", d),    64'(busy[d]), 64'd0);
            check($sformatf("reset d%0d done", d),    64'(done[d]), 64'd0);
            check($sformatf("reset d%0d product", d), product[d],   64'd0);
            check($sformatf("reset d%0d ovf", d),     64'(ovf[d]),  64'd0);
        end
        reset    = 1'b0;
        check_en = 1'b1;

        check("model 7x-3",        ref_mul(32'd7, 32'hFFFFFFFD, 1'b1), 64'hFFFFFFFF_FFFFFFEB);
        check("model ovf 7x-3",    64'(ref_ovf(64'hFFFFFFFF_FFFFFFEB, 1'b1)), 64'd0);
        check("model min sq",      ref_mul(32'h80000000, 32'h80000000, 1'b1), 64'h40000000_00000000);
        check("model ovf min sq",  64'(ref_ovf(64'h40000000_00000000, 1'b1)), 64'd1);
        check("model ones u",      ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE_00000001);
        check("model ones s",      ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1), 64'd1);

        do_op(0, 32'd7, 32'hFFFFFFFD, 1'b1, -1, 1'b0, p, o, lat, bc);
        check("r2 7x-3 product", p, 64'hFFFFFFFF_FFFFFFEB);
        check("r2 7x-3 ovf",     64'(o), 64'd0);
        check("r2 7x-3 latency", 64'(lat), 64'd35);
        check("r2 7x-3 busy cycles", 64'(bc), 64'd34);

        for (int d = 0; d < 2; d++) begin
            do_op(d, 32'h80000000, 32'h80000000, 1'b1, -1, 1'b0, p, o, lat, bc);
            check($sformatf("d%0d min sq product", d), p, 64'h40000000_00000000);
            check($sformatf("d%0d min sq ovf", d), 64'(o), 64'd1);
            check($sformatf("d%0d min sq latency", d), 64'(lat), (d == 0) ? 64'd35 : 64'd18);
            do_op(d, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 1'b0, p, o, lat, bc);
            check($sformatf("d%0d ones u product", d), p, 64'hFFFFFFFE_00000001);
            check($sformatf("d%0d ones u ovf", d), 64'(o), 64'd1);
            do_op(d, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, -1, 1'b0, p, o, lat, bc);
            check($sformatf("d%0d ones s product", d), p, 64'd1);
            check($sformatf("d%0d ones s ovf", d), 64'(o), 64'd0);
        end

        for (int d = 0; d < 2; d++) begin
            do_op(d, 32'd5, 32'd6, 1'b0, 9, 1'b0, p, o, lat, bc);
            check($sformatf("d%0d ignore start product", d), p, 64'h1E);
            check($sformatf("d%0d ignore start ovf", d), 64'(o), 64'd0);
            check($sformatf("d%0d ignore start latency", d), 64'(lat), (d == 0) ? 64'd35 : 64'd18);
        end

        // back-to-back: start held high through the DONE cycle
        @(negedge clk);
        start[0] = 1'b1; mcand[0] = 32'd7; mplier[0] = 32'd9; signed_op[0] = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done[0]) begin
                lat = i;
                break;
            end
            mcand[0] = 32'h10; mplier[0] = 32'h10;
        end
        check("b2b first latency", 64'(lat), 64'd35);
        check("b2b first product", product[0], 64'd63);
        @(negedge clk);
        start[0] = 1'b0;
        check("b2b restart busy",    64'(busy[0]), 64'd1);
        check("b2b restart done",    64'(done[0]), 64'd0);
        check("b2b restart product", product[0],   64'd0);
        lat = -1;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (done[0]) begin
                lat = i;
                break;
            end
        end
        check("b2b second latency", 64'(lat), 64'd35);
        check("b2b second product", product[0], 64'h100);

        // randomized operations, with start/operand noise during runs
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 2; d++) begin
                ra = rand_operand(); rb = rand_operand(); rs = 1'($urandom_range(1));
                do_op(d, ra, rb, rs, -1, 1'($urandom_range(1)), p, o, lat, bc);
                check($sformatf("rand d%0d product", d), p, ref_mul(ra, rb, rs));
                check($sformatf("rand d%0d ovf", d), 64'(o), 64'(ref_ovf(ref_mul(ra, rb, rs), rs)));
            end
        end

        // asynchronous reset mid-run, with the other instance holding a result
        do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 1'b0, p, o, lat, bc);
        @(negedge clk);
        start[0] = 1'b1; mcand[0] = 32'd5; mplier[0] = 32'd6; signed_op[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async reset d%0d busy", d),    64'(busy[d]), 64'd0);
            check($sformatf("async reset d%0d done", d),    64'(done[d]), 64'd0);
            check($sformatf("async reset d%0d product", d), product[d],   64'd0);
            check($sformatf("async reset d%0d ovf", d),     64'(ovf[d]),  64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_op(0, 32'd2, 32'd3, 1'b0, -1, 1'b0, p, o, lat, bc);
        check("after reset product", p, 64'd6);
        check("after reset latency", 64'(lat), 64'd35);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
